// File: rtl/fuzzy_rule_engine.sv
// Two-stage fuzzy rule-base lookup: (fuzzy_E, fuzzy_EC) -> fuzzy_df through a
// run-time programmable rule table, with valid/ready flow control and OOR tracking.
module fuzzy_rule_engine #(
    parameter int IDX_W       = 5,
    parameter int N_E         = 9,
    parameter int N_EC        = 17,
    parameter int OUT_W       = 5,
    parameter int DEFAULT_OUT = 7
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IDX_W-1:0] fuzzy_E,
    input  logic [IDX_W-1:0] fuzzy_EC,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] fuzzy_df,
    output logic             out_oor,
    input  logic             cfg_we,
    input  logic [IDX_W-1:0] cfg_e,
    input  logic [IDX_W-1:0] cfg_ec,
    input  logic [OUT_W-1:0] cfg_data,
    output logic             cfg_err,
    output logic [15:0]      oor_cnt
);
    localparam int DEPTH = N_E * N_EC;
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef logic [DEPTH-1:0][OUT_W-1:0] tbl_t;

    // Reset image: every row is the identity map on EC.
    function automatic tbl_t tbl_ident();
        tbl_t r;
        for (int i = 0; i < DEPTH; i++) r[AW'(i)] = OUT_W'(i % N_EC);
        return r;
    endfunction

    localparam tbl_t TBL_RST = tbl_ident();

    tbl_t             tbl_q, tbl_d;
    logic             s1_valid_q, s1_valid_d;
    logic [IDX_W-1:0] s1_e_q, s1_e_d, s1_ec_q, s1_ec_d;
    logic             s1_oor_q, s1_oor_d;
    logic             s2_valid_q, s2_valid_d;
    logic [OUT_W-1:0] s2_df_q, s2_df_d;
    logic             s2_oor_q, s2_oor_d;
    logic             cfg_err_q, cfg_err_d;
    logic [15:0]      oor_cnt_q, oor_cnt_d;

    logic             adv, in_oor, wr_ok;
    logic [AW-1:0]    rd_addr, wr_addr;

    always_comb begin
        adv     = !s2_valid_q || out_ready;
        in_oor  = (32'(fuzzy_E) >= N_E) || (32'(fuzzy_EC) >= N_EC);
        wr_ok   = cfg_we && (32'(cfg_e) < N_E) && (32'(cfg_ec) < N_EC);
        rd_addr = AW'(32'(s1_e_q) * N_EC + 32'(s1_ec_q));
        wr_addr = AW'(32'(cfg_e) * N_EC + 32'(cfg_ec));

        tbl_d      = tbl_q;
        cfg_err_d  = cfg_err_q || (cfg_we && !wr_ok);
        s1_valid_d = s1_valid_q;
        s1_e_d     = s1_e_q;
        s1_ec_d    = s1_ec_q;
        s1_oor_d   = s1_oor_q;
        s2_valid_d = s2_valid_q;
        s2_df_d    = s2_df_q;
        s2_oor_d   = s2_oor_q;
        oor_cnt_d  = oor_cnt_q;

        // Writes ignore the stall; the S2 read below still sees the pre-edge table.
        if (wr_ok) tbl_d[wr_addr] = cfg_data;

        if (adv) begin
            s1_valid_d = in_valid;
            if (in_valid) begin
                s1_e_d   = fuzzy_E;
                s1_ec_d  = fuzzy_EC;
                s1_oor_d = in_oor;
            end
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_df_d  = s1_oor_q ? OUT_W'(DEFAULT_OUT) : tbl_q[rd_addr];
                s2_oor_d = s1_oor_q;
                if (s1_oor_q && oor_cnt_q != 16'hFFFF) oor_cnt_d = oor_cnt_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tbl_q      <= TBL_RST;
            cfg_err_q  <= 1'b0;
            s1_valid_q <= 1'b0;
            s1_e_q     <= '0;
            s1_ec_q    <= '0;
            s1_oor_q   <= 1'b0;
            s2_valid_q <= 1'b0;
            s2_df_q    <= '0;
            s2_oor_q   <= 1'b0;
            oor_cnt_q  <= '0;
        end else begin
            tbl_q      <= tbl_d;
            cfg_err_q  <= cfg_err_d;
            s1_valid_q <= s1_valid_d;
            s1_e_q     <= s1_e_d;
            s1_ec_q    <= s1_ec_d;
            s1_oor_q   <= s1_oor_d;
            s2_valid_q <= s2_valid_d;
            s2_df_q    <= s2_df_d;
            s2_oor_q   <= s2_oor_d;
            oor_cnt_q  <= oor_cnt_d;
        end
    end

    assign in_ready  = adv;
    assign out_valid = s2_valid_q;
    assign fuzzy_df  = s2_df_q;
    assign out_oor   = s2_oor_q;
    assign cfg_err   = cfg_err_q;
    assign oor_cnt   = oor_cnt_q;
endmodule

// File: tb/tb_fuzzy_rule_engine.sv
// Directed bench for fuzzy_rule_engine with hand-computed expected labels.
module tb_fuzzy_rule_engine;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0, in_ready;
    logic [4:0] fuzzy_E = '0, fuzzy_EC = '0;
    logic       out_valid, out_ready = 1'b1;
    logic [4:0] fuzzy_df;
    logic       out_oor;
    logic       cfg_we = 1'b0;
    logic [4:0] cfg_e = '0, cfg_ec = '0, cfg_data = '0;
    logic       cfg_err;
    logic [15:0] oor_cnt;

    int n_chk = 0;
    int n_bad = 0;

    fuzzy_rule_engine dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .fuzzy_E(fuzzy_E), .fuzzy_EC(fuzzy_EC),
        .out_valid(out_valid), .out_ready(out_ready),
        .fuzzy_df(fuzzy_df), .out_oor(out_oor),
        .cfg_we(cfg_we), .cfg_e(cfg_e), .cfg_ec(cfg_ec), .cfg_data(cfg_data),
        .cfg_err(cfg_err), .oor_cnt(oor_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Single isolated lookup on an empty pipeline: result appears 2 edges later.
    task automatic lookup(input string tag, input logic [4:0] e, input logic [4:0] ec,
                          input logic [4:0] exp_df, input logic exp_oor);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        fuzzy_E   = e;
        fuzzy_EC  = ec;
        step();
        in_valid = 1'b0;
        step();
        chk({tag, "_vld"}, 32'(out_valid), 32'd1);
        chk({tag, "_df"},  32'(fuzzy_df),  32'(exp_df));
        chk({tag, "_oor"}, 32'(out_oor),   32'(exp_oor));
        step();
    endtask

    task automatic cfg_write(input logic [4:0] e, input logic [4:0] ec, input logic [4:0] d);
        cfg_we   = 1'b1;
        cfg_e    = e;
        cfg_ec   = ec;
        cfg_data = d;
        step();
        cfg_we = 1'b0;
    endtask

    initial begin
        logic [3:0] pat;
        int sent, rcvd;
        logic fire_in, fire_out;

        // T1: reset state and back-to-back lookups
        #12;
        chk("rst_vld",     32'(out_valid), 32'd0);
        chk("rst_df",      32'(fuzzy_df),  32'd0);
        chk("rst_oor",     32'(out_oor),   32'd0);
        chk("rst_cfg_err", 32'(cfg_err),   32'd0);
        chk("rst_oor_cnt", 32'(oor_cnt),   32'd0);
        chk("rst_in_rdy",  32'(in_ready),  32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        in_valid = 1'b1; fuzzy_E = 5'd0; fuzzy_EC = 5'd3;
        step();
        chk("t1_lat1_vld", 32'(out_valid), 32'd0);
        fuzzy_E = 5'd4; fuzzy_EC = 5'd16;
        step();
        in_valid = 1'b0;
        chk("t1_a_vld", 32'(out_valid), 32'd1);
        chk("t1_a_df",  32'(fuzzy_df),  32'd3);
        step();
        chk("t1_b_vld", 32'(out_valid), 32'd1);
        chk("t1_b_df",  32'(fuzzy_df),  32'd16);
        step();
        chk("t1_drain", 32'(out_valid), 32'd0);

        // T2: out-of-range inputs
        lookup("t2_e9",  5'd9, 5'd2,  5'd7, 1'b1);
        lookup("t2_ec17", 5'd1, 5'd17, 5'd7, 1'b1);
        chk("t2_oor_cnt", 32'(oor_cnt), 32'd2);
        lookup("t2_inr", 5'd4, 5'd5, 5'd5, 1'b0);
        lookup("t2_corner", 5'd8, 5'd16, 5'd16, 1'b0);
        chk("t2_oor_cnt2", 32'(oor_cnt), 32'd2);

        // T3: 8-pair stream under out_ready pattern 1,0,0,1
        pat = 4'b1001;
        sent = 0; rcvd = 0;
        in_valid = 1'b1; fuzzy_E = 5'd0; fuzzy_EC = 5'd0;
        for (int cyc = 0; cyc < 100 && rcvd < 8; cyc++) begin
            out_ready = pat[2'(cyc)];
            #1;
            chk("t3_in_ready", 32'(in_ready), 32'(!out_valid || out_ready));
            fire_in  = in_valid && in_ready;
            fire_out = out_valid && out_ready;
            if (fire_out) begin
                chk("t3_df", 32'(fuzzy_df), 32'((rcvd * 3) % 17));
                rcvd++;
            end
            step();
            if (fire_in) begin
                sent++;
                if (sent < 8) begin
                    fuzzy_E  = 5'(sent % 9);
                    fuzzy_EC = 5'((sent * 3) % 17);
                end else begin
                    in_valid = 1'b0;
                end
            end
        end
        chk("t3_rcvd", 32'(rcvd), 32'd8);
        out_ready = 1'b1;
        step();
        chk("t3_no_extra", 32'(out_valid), 32'd0);

        // T4: table programming and bad-address write
        cfg_write(5'd2, 5'd5, 5'd12);
        lookup("t4_prog",  5'd2, 5'd5, 5'd12, 1'b0);
        lookup("t4_other", 5'd3, 5'd5, 5'd5,  1'b0);
        chk("t4_err_clr", 32'(cfg_err), 32'd0);
        cfg_write(5'd9, 5'd0, 5'd3);
        chk("t4_err_set", 32'(cfg_err), 32'd1);
        lookup("t4_unch0", 5'd0, 5'd0,  5'd0,  1'b0);
        lookup("t4_unch8", 5'd8, 5'd16, 5'd16, 1'b0);
        chk("t4_err_sticky", 32'(cfg_err), 32'd1);

        // T5: write collides with a lookup advancing S1->S2
        in_valid = 1'b1; fuzzy_E = 5'd1; fuzzy_EC = 5'd1;
        step();
        cfg_we = 1'b1; cfg_e = 5'd1; cfg_ec = 5'd1; cfg_data = 5'd20;
        step();
        cfg_we = 1'b0; in_valid = 1'b0;
        chk("t5_old_vld", 32'(out_valid), 32'd1);
        chk("t5_old_df",  32'(fuzzy_df),  32'd1);
        step();
        chk("t5_new_vld", 32'(out_valid), 32'd1);
        chk("t5_new_df",  32'(fuzzy_df),  32'd20);
        step();

        // T6: reset mid-stream restores the identity table
        in_valid = 1'b1; fuzzy_E = 5'd2; fuzzy_EC = 5'd5;
        step();
        step();
        chk("t6_pre_vld", 32'(out_valid), 32'd1);
        chk("t6_pre_df",  32'(fuzzy_df),  32'd12);
        rst_n = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("t6_rst_vld",  32'(out_valid), 32'd0);
        chk("t6_rst_err",  32'(cfg_err),   32'd0);
        chk("t6_rst_cnt",  32'(oor_cnt),   32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        lookup("t6_ident", 5'd2, 5'd5, 5'd5, 1'b0);
        lookup("t6_ident11", 5'd1, 5'd1, 5'd1, 1'b0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
